mux4_arbiter: RTL and testbench
===============================

Name: mux4_arbiter

Overview:
- Round-robin arbiter and select sequencer for a shared 4:1 mux path.
- Four requesters compete for the single mux output.
- Drives the mux `sel[1:0]` and a one-hot grant. Holds each grant for a bounded burst.
- Inserts a one-cycle idle turnaround between owners, so the gate-delayed mux settles before the next owner drives it.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  4  request vector; bit i = requester i wants the mux.
- grant  output  4  one-hot grant; all-zero when idle.
- sel  output  2  mux select; encoded index of current or most recent owner.
- busy  output  1  high while any grant is active.
- grant_cnt  output  16  total grants issued; present only with MUX4_ARB_STATS_EN.

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - Reset `rst` is asynchronous and active-high.
  - Asserting `rst` immediately forces: grant=0, sel=0, busy=0, last_owner=3, hold_cnt=0, state=IDLE, grant_cnt=0.
  - last_owner=3 makes requester 0 highest priority after reset.
- State IDLE:
  - grant=0, busy=0.
  - sel keeps its previous value and never changes while idle, to avoid glitching the mux.
  - If req!=0 at a rising edge: winner = first set bit scanning (last_owner+1) mod 4 upward with wrap.
  - Register grant=onehot(winner), sel=winner, busy=1, hold_cnt=0; go to BUSY.
  - Latency: req sampled at edge N gives grant visible after edge N (1 cycle).
- State BUSY:
  - grant, sel and busy are stable. hold_cnt increments each cycle.
  - Release condition: req[sel]==0, OR hold_cnt==MAX_HOLD-1.
  - On release at an edge: grant=0, busy=0, last_owner=sel, hold_cnt=0, go to IDLE. sel unchanged.
  - A grant therefore lasts between 1 and MAX_HOLD cycles.
  - There is always exactly one idle cycle between consecutive grants.
- Fairness:
  - After a timeout, the same requester is re-granted only if no other requester is asserting.
  - Worst-case wait for any asserted requester: 3*(MAX_HOLD+1)+1 cycles.
- Request changes:
  - Requests from non-owners changing during BUSY have no effect until IDLE.
  - An owner that drops req and re-raises it in the IDLE cycle competes normally, with lowest priority.
- MAX_HOLD=1: every grant lasts exactly one cycle, giving an alternating grant/idle pattern.
- Invariants:
  - grant is always zero or one-hot.
  - When grant!=0, grant[sel]==1.
  - busy == |grant.
- hold_cnt width is 8 bits and cannot overflow within the legal MAX_HOLD range.
- Reset mid-BUSY: outputs clear asynchronously. The first grant after release follows the reset priority (requester 0 first).

Optional Feature:
- Macro: MUX4_ARB_STATS_EN.
- Defined:
  - Port grant_cnt[15:0] exists.
  - It increments by 1 on each IDLE→BUSY transition and saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Single request: rst pulse, then req=4'b0001 held → grant=4'b0001, sel=0, busy=1 one cycle later; with MAX_HOLD=4, grant lasts 4 cycles, then 1 idle cycle, then re-granted to requester 0.
- Round-robin: req=4'b1111 held, MAX_HOLD=4 → grant sequence 0001,0010,0100,1000,0001, each 4 cycles with 1 idle cycle between; sel steps 0,1,2,3,0.
- Early release: req=4'b0100, drop req[2] after 2 grant cycles → grant 0100 for exactly 2 cycles, then grant=0, sel stays 2 during idle.
- Priority after last owner: owner 1 releases while req=4'b0011 → next grant 0001 only if bit 2/3 absent, scanning 2,3,0 → grant=0001.
- Reset mid-grant: assert rst asynchronously during grant=4'b1000 → grant=0, sel=0, busy=0 before the next edge; after release with req=4'b1001 → grant=4'b0001 first.
- Stats (MUX4_ARB_STATS_EN): 5 complete grants → grant_cnt=5; preload via long run to 16'hFFFF → stays 16'hFFFF after further grants.

Source files
------------

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux: one-hot grant, encoded select, bounded burst, idle turnaround.
// Optional grant counter port enabled by defining MUX4_ARB_STATS_EN.
module mux4_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy
`ifdef MUX4_ARB_STATS_EN
  ,
  output logic [15:0] grant_cnt
`endif
);

  localparam int unsigned HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nx;
  logic [3:0]        grant_nx;
  logic [1:0]        sel_nx;
  logic              busy_nx;
  logic [1:0]        last_owner, last_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic [1:0]        winner;

  // Scan from last_owner+1 upward with wrap; the lowest offset with a request wins.
  always_comb begin
    winner = '0;
    for (int k = 4; k >= 1; k--) begin
      if (req[2'(int'(last_owner) + k)]) winner = 2'(int'(last_owner) + k);
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    sel_nx   = sel;
    busy_nx  = busy;
    last_nx  = last_owner;
    hold_nx  = hold_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nx = 4'(4'b0001 << winner);
          sel_nx   = winner;
          busy_nx  = 1'b1;
          hold_nx  = '0;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        // sel is left alone on release so the mux input does not glitch while idle.
        if (!req[sel] || hold_cnt == HOLD_LAST) begin
          grant_nx = '0;
          busy_nx  = 1'b0;
          last_nx  = sel;
          hold_nx  = '0;
          state_nx = IDLE;
        end else begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      sel        <= '0;
      busy       <= 1'b0;
      last_owner <= 2'd3;
      hold_cnt   <= '0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      sel        <= sel_nx;
      busy       <= busy_nx;
      last_owner <= last_nx;
      hold_cnt   <= hold_nx;
    end
  end

`ifdef MUX4_ARB_STATS_EN
  logic [15:0] grant_cnt_nx;

  // Saturating count of IDLE->BUSY transitions.
  always_comb begin
    grant_cnt_nx = grant_cnt;
    if (state == IDLE && (|req) && grant_cnt != 16'hFFFF) grant_cnt_nx = grant_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) grant_cnt <= '0;
    else     grant_cnt <= grant_cnt_nx;
  end
`endif

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed, table-driven bench for mux4_arbiter (MAX_HOLD=4 main instance, MAX_HOLD=1 side instance).
module tb_mux4_arbiter;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req1;
  logic [3:0] grant, grant1;
  logic [1:0] sel, sel1;
  logic       busy, busy1;
`ifdef MUX4_ARB_STATS_EN
  logic [15:0] grant_cnt, grant_cnt1;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mux4_arbiter #(.MAX_HOLD(4)) u_dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .sel(sel), .busy(busy)
`ifdef MUX4_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  mux4_arbiter #(.MAX_HOLD(1)) u_one (
    .clk(clk), .rst(rst), .req(req1), .grant(grant1), .sel(sel1), .busy(busy1)
`ifdef MUX4_ARB_STATS_EN
    , .grant_cnt(grant_cnt1)
`endif
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s, input logic b);
    vec_t v;
    v.req = r; v.grant = g; v.sel = s; v.busy = b;
    tbl.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] g, input logic [1:0] s, input logic b);
    check({tag, ".grant"}, 16'(grant), 16'(g));
    check({tag, ".sel"},   16'(sel),   16'(s));
    check({tag, ".busy"},  16'(busy),  16'(b));
  endtask

  initial begin
    int exp_grants;
    logic prev_busy;
    logic [3:0] one_g[8];
    logic [1:0] one_s[8];

    rst = 1'b1; req = '0; req1 = '0;
    #2;
    check_outputs("reset", 4'b0000, 2'd0, 1'b0);
    step(); step();
    rst = 1'b0;

    // single request held: 4-cycle burst, one idle, re-grant to 0
    add(4'b0001, 4'b0001, 2'd0, 1'b1);
    add(4'b0001, 4'b0001, 2'd0, 1'b1);
    add(4'b0001, 4'b0001, 2'd0, 1'b1);
    add(4'b0001, 4'b0001, 2'd0, 1'b1);
    add(4'b0001, 4'b0000, 2'd0, 1'b0);
    add(4'b0001, 4'b0001, 2'd0, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    // round robin with all requesting: 1,2,3,0
    for (int i = 0; i < 4; i++) add(4'b1111, 4'b0010, 2'd1, 1'b1);
    add(4'b1111, 4'b0000, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) add(4'b1111, 4'b0100, 2'd2, 1'b1);
    add(4'b1111, 4'b0000, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) add(4'b1111, 4'b1000, 2'd3, 1'b1);
    add(4'b1111, 4'b0000, 2'd3, 1'b0);
    add(4'b1111, 4'b0001, 2'd0, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    // early release of requester 2 after two cycles; sel holds during idle
    add(4'b0100, 4'b0100, 2'd2, 1'b1);
    add(4'b0100, 4'b0100, 2'd2, 1'b1);
    add(4'b0000, 4'b0000, 2'd2, 1'b0);
    add(4'b0000, 4'b0000, 2'd2, 1'b0);
    // owner 1 times out with req=0011: next scan 2,3,0 picks 0
    add(4'b0010, 4'b0010, 2'd1, 1'b1);
    add(4'b0011, 4'b0010, 2'd1, 1'b1);
    add(4'b0011, 4'b0010, 2'd1, 1'b1);
    add(4'b0011, 4'b0010, 2'd1, 1'b1);
    add(4'b0011, 4'b0000, 2'd1, 1'b0);
    add(4'b0011, 4'b0001, 2'd0, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    // owner drops and re-raises in the idle cycle: lowest priority
    add(4'b0011, 4'b0010, 2'd1, 1'b1);
    add(4'b0001, 4'b0000, 2'd1, 1'b0);
    add(4'b0011, 4'b0001, 2'd0, 1'b1);
    // non-owner changes during busy are ignored
    add(4'b1111, 4'b0001, 2'd0, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);

    exp_grants = 0;
    prev_busy = 1'b0;
    foreach (tbl[i]) begin
      req = tbl[i].req;
      step();
      check_outputs($sformatf("vec%0d", i), tbl[i].grant, tbl[i].sel, tbl[i].busy);
      check($sformatf("vec%0d.inv", i), 16'(busy == (|grant) && $onehot0(grant)), 16'd1);
      if (tbl[i].busy && !prev_busy) exp_grants++;
      prev_busy = tbl[i].busy;
    end
`ifdef MUX4_ARB_STATS_EN
    check("grant_cnt", grant_cnt, 16'(exp_grants));
`endif

    // asynchronous reset in the middle of a grant to requester 3
    req = 4'b1000;
    step();
    check_outputs("own3", 4'b1000, 2'd3, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_outputs("async_rst", 4'b0000, 2'd0, 1'b0);
`ifdef MUX4_ARB_STATS_EN
    check("grant_cnt_rst", grant_cnt, 16'd0);
`endif
    req = 4'b1001;
    step();
    rst = 1'b0;
    step();
    check_outputs("post_rst", 4'b0001, 2'd0, 1'b1);
    req = '0;
    step();

    // MAX_HOLD=1: alternating grant / idle with rotation
    one_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
    one_s = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    check("one.idle", 16'(grant1), 16'd0);
    req1 = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("one%0d.grant", i), 16'(grant1), 16'(one_g[i]));
      check($sformatf("one%0d.sel", i),   16'(sel1),   16'(one_s[i]));
      check($sformatf("one%0d.busy", i),  16'(busy1),  16'(one_g[i] != 4'b0000));
    end
    req1 = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
